// File: rtl/alu_mc_pkg.sv
// alu_mc_pkg: opcode values and FSM state encoding shared by the multi-cycle ALU.
package alu_mc_pkg;
    localparam logic [3:0] OP_AND = 4'h0;
    localparam logic [3:0] OP_OR  = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_XOR = 4'h3;
    localparam logic [3:0] OP_SLL = 4'h4;
    localparam logic [3:0] OP_SRL = 4'h5;
    localparam logic [3:0] OP_SUB = 4'h6;
    localparam logic [3:0] OP_SLT = 4'h7;
    localparam logic [3:0] OP_MUL = 4'h8;
    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
endpackage

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand/result valid-ready bus of the multi-cycle ALU.
interface alu_mc_if #(parameter int WIDTH = 32, parameter int CTRL_W = 4);
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  a;
    logic [WIDTH-1:0]  b;
    logic [CTRL_W-1:0] alu_control;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  result;
    logic              zero;
    logic              carry;
    logic              overflow;
    modport master (output in_valid, a, b, alu_control, out_ready,
                    input in_ready, out_valid, result, zero, carry, overflow);
    modport slave  (input in_valid, a, b, alu_control, out_ready,
                    output in_ready, out_valid, result, zero, carry, overflow);
endinterface

// File: rtl/alu_mc_mul.sv
// alu_mul_iter: unsigned shift-add multiplier, one multiplier bit per cycle over WIDTH cycles.
module alu_mul_iter #(parameter int WIDTH = 32) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product
);
    localparam int CW = $clog2(WIDTH);
    logic [WIDTH-1:0] mcand, mplier, acc, next_acc;
    logic [CW-1:0]    cnt;
    assign next_acc = acc + (mplier[0] ? mcand : '0);
    // done and product cover the final iteration so the result lands on the same edge
    assign done     = busy & (cnt == CW'(WIDTH - 1));
    assign product  = next_acc;
    always_ff @(posedge clk) begin
        if (reset) begin
            busy   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            acc    <= '0;
            mcand  <= a;
            mplier <= b;
        end else if (busy) begin
            acc    <= next_acc;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            busy   <= ~done;
        end
    end
endmodule

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU with valid/ready handshake, registered result/flags and iterative multiply.
module alu_mc
    import alu_mc_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4
) (
    input logic     clk,
    input logic     reset,
    alu_mc_if.slave bus
);
    localparam int SH_W = $clog2(WIDTH);
    localparam int M    = WIDTH - 1;
    state_t           state;
    logic             accept, is_mul, mul_busy, mul_done, c, v;
    logic [WIDTH-1:0] res, mul_p;
    logic [WIDTH:0]   sum, diff;
    logic [SH_W-1:0]  sh;
    assign bus.in_ready = ((state == IDLE) | ((state == DONE) & bus.out_ready)) & ~mul_busy;
    assign accept = bus.in_valid & bus.in_ready;
    assign is_mul = bus.alu_control == CTRL_W'(OP_MUL);
    assign sum    = {1'b0, bus.a} + {1'b0, bus.b};
    assign diff   = {1'b0, bus.a} - {1'b0, bus.b};
    assign sh     = bus.b[SH_W-1:0];
    always_comb begin
        res = '0;
        c   = 1'b0;
        v   = 1'b0;
        case (bus.alu_control)
            CTRL_W'(OP_AND): res = bus.a & bus.b;
            CTRL_W'(OP_OR):  res = bus.a | bus.b;
            CTRL_W'(OP_XOR): res = bus.a ^ bus.b;
            CTRL_W'(OP_SLL): res = bus.a << sh;
            CTRL_W'(OP_SRL): res = bus.a >> sh;
            CTRL_W'(OP_SLT): res = WIDTH'($signed(bus.a) < $signed(bus.b));
            CTRL_W'(OP_ADD): begin
                res = sum[M:0];
                c   = sum[WIDTH];
                v   = (bus.a[M] == bus.b[M]) & (sum[M] != bus.a[M]);
            end
            CTRL_W'(OP_SUB): begin
                res = diff[M:0];
                c   = ~diff[WIDTH];
                v   = (bus.a[M] != bus.b[M]) & (diff[M] != bus.a[M]);
            end
            default: ;
        endcase
    end
    alu_mul_iter #(.WIDTH(WIDTH)) u_mul (
        .clk    (clk),
        .reset  (reset),
        .start  (accept & is_mul),
        .a      (bus.a),
        .b      (bus.b),
        .busy   (mul_busy),
        .done   (mul_done),
        .product(mul_p)
    );
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.out_valid <= 1'b0;
            bus.result   <= '0;
            bus.zero     <= 1'b1;
            bus.carry    <= 1'b0;
            bus.overflow <= 1'b0;
        end else if (accept && is_mul) begin
            state         <= BUSY;
            bus.out_valid <= 1'b0;
        end else if (accept) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= res;
            bus.zero      <= res == '0;
            bus.carry     <= c;
            bus.overflow  <= v;
        end else if (state == BUSY && mul_done) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
            bus.result    <= mul_p;
            bus.zero      <= mul_p == '0;
            bus.carry     <= 1'b0;
            bus.overflow  <= 1'b0;
        end else if (state == DONE && bus.out_ready) begin
            state         <= IDLE;
            bus.out_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc with hand-computed expectations.
module tb_alu_mc;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int   total = 0;
    int   bad = 0;
    always #5 clk = ~clk;
    alu_mc_if #(.WIDTH(32), .CTRL_W(4)) bus ();
    alu_mc #(.WIDTH(32), .CTRL_W(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // drive one op at a negedge, let one posedge pass, leave in_valid low
    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        bus.in_valid = 1'b1;
        bus.a = a;
        bus.b = b;
        bus.alu_control = op;
        #1;
        chk("in_ready_before_issue", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic out_chk(input string tag, input logic [31:0] r, input logic z, input logic c, input logic v);
        chk({tag, "_valid"}, {31'b0, bus.out_valid}, 32'd1);
        chk({tag, "_result"}, bus.result, r);
        chk({tag, "_zero"}, {31'b0, bus.zero}, {31'b0, z});
        chk({tag, "_carry"}, {31'b0, bus.carry}, {31'b0, c});
        chk({tag, "_overflow"}, {31'b0, bus.overflow}, {31'b0, v});
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.alu_control = '0;
        bus.out_ready = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);
            chk("idle_out_valid", {31'b0, bus.out_valid}, 32'd0);
            chk("idle_result", bus.result, 32'd0);
            chk("idle_zero", {31'b0, bus.zero}, 32'd1);
        end
        bus.out_ready = 1'b1;
        issue(32'hFFFF_FFFF, 32'd1, 4'h2);
        out_chk("add_wrap", 32'h0, 1'b1, 1'b1, 1'b0);
        issue(32'h7FFF_FFFF, 32'd1, 4'h2);
        out_chk("add_ovf", 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        issue(32'd3, 32'd5, 4'h6);
        out_chk("sub_borrow", 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
        issue(32'd5, 32'd3, 4'h6);
        out_chk("sub_noborrow", 32'd2, 1'b0, 1'b1, 1'b0);
        issue(32'h8000_0000, 32'h7FFF_FFFF, 4'h6);
        out_chk("sub_ovf", 32'h0000_0001, 1'b0, 1'b1, 1'b1);
        issue(32'h8000_0000, 32'd1, 4'h7);
        out_chk("slt", 32'd1, 1'b0, 1'b0, 1'b0);
        issue(32'd1, 32'd31, 4'h4);
        out_chk("sll31", 32'h8000_0000, 1'b0, 1'b0, 1'b0);
        issue(32'h8000_0000, 32'h21, 4'h5);
        out_chk("srl_lowbits", 32'h4000_0000, 1'b0, 1'b0, 1'b0);
        issue(32'hF0F0, 32'h0FF0, 4'h0);
        out_chk("and", 32'h00F0, 1'b0, 1'b0, 1'b0);
        // MUL, with a competing ADD 1+1 held valid throughout BUSY
        issue(32'h0001_0003, 32'd7, 4'h8);
        bus.in_valid = 1'b1;
        bus.a = 32'd1;
        bus.b = 32'd1;
        bus.alu_control = 4'h2;
        for (int i = 1; i <= 32; i++) begin
            chk("mul_busy_in_ready", {31'b0, bus.in_ready}, 32'd0);
            chk("mul_busy_out_valid", {31'b0, bus.out_valid}, 32'd0);
            @(negedge clk);
        end
        out_chk("mul", 32'h0007_0015, 1'b0, 1'b0, 1'b0);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mul_drain_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("mul_hold_result", bus.result, 32'h0007_0015);
        // backpressure then back-to-back
        bus.out_ready = 1'b0;
        issue(32'hF0F0, 32'h0FF0, 4'h3);
        bus.in_valid = 1'b1;
        bus.a = 32'd1;
        bus.b = 32'd2;
        bus.alu_control = 4'h1;
        for (int i = 0; i < 4; i++) begin
            out_chk("xor_stall", 32'hFF00, 1'b0, 1'b0, 1'b0);
            chk("xor_stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", {31'b0, bus.in_ready}, 32'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        out_chk("b2b_or", 32'd3, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        chk("b2b_idle_valid", {31'b0, bus.out_valid}, 32'd0);
        // reset during the 10th BUSY cycle of a multiply
        issue(32'h0001_0003, 32'd7, 4'h8);
        repeat (9) @(negedge clk);
        chk("mul10_busy", {31'b0, bus.in_ready}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("abort_result", bus.result, 32'd0);
        chk("abort_zero", {31'b0, bus.zero}, 32'd1);
        chk("abort_in_ready", {31'b0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            chk("abort_no_output", {31'b0, bus.out_valid}, 32'd0);
        end
        issue(32'd2, 32'd2, 4'h2);
        out_chk("add_after_abort", 32'd4, 1'b0, 1'b0, 1'b0);
        issue(32'd5, 32'd3, 4'hF);
        out_chk("bad_opcode", 32'd0, 1'b1, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/alu_mc.md
Name: alu_mc

Overview:
- Parametrised, multi-cycle successor to the datapath ALU.
- Adds a valid/ready handshake on input and output, registered results, and a wider operation set with ADD/SUB flags.
- Adds an iterative shift-add multiply.
- Sits between register-read and writeback in the execution-cycle datapath. Address computation (ADD) keeps its existing 3'b010 opcode value.

Parameters:
- WIDTH, 32, operand/result width (>=8, power of 2).
- CTRL_W, 4, alu_control width; opcodes are zero-extended 4-bit values.
- SH_W, $clog2(WIDTH), derived: shift-amount bits taken from b.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  operands/opcode valid.
- in_ready  out  1  block can accept an operation.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- alu_control  in  CTRL_W  opcode.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer takes result.
- result  out  WIDTH  registered result.
- zero  out  1  result == 0.
- carry  out  1  ADD carry-out / SUB no-borrow; 0 for other ops.
- overflow  out  1  signed overflow for ADD/SUB; 0 for other ops.

Behaviour:
- Opcodes:
  - 0000 AND
  - 0001 OR
  - 0010 ADD
  - 0011 XOR
  - 0100 SLL (a << b[SH_W-1:0])
  - 0101 SRL (logical)
  - 0110 SUB (a-b)
  - 0111 SLT (signed, result 1/0)
  - 1000 MUL (low WIDTH bits of a*b, unsigned)
  - any other value: result 0, zero 1, carry 0, overflow 0.
- FSM states IDLE, BUSY, DONE.
- Reset: state IDLE; out_valid 0, result 0, zero 1, carry 0, overflow 0; multiply counter and accumulator 0.
- Accept: the handshake (in_valid & in_ready) latches a, b and the opcode.
- in_ready = (state==IDLE) | (state==DONE & out_ready). Back-to-back issue is allowed, giving one op per cycle under continuous out_ready.
- Non-MUL ops: result and flags are registered on the accept edge; state goes to DONE; out_valid is high on the next cycle. Latency 1.
- MUL: accept → BUSY.
  - Shift-add of one multiplier bit per cycle, WIDTH cycles; counter runs 0..WIDTH-1.
  - After the last iteration, go to DONE with the product.
  - Latency WIDTH+1 cycles from accept to out_valid.
  - Flags: zero valid; carry 0; overflow 0.
- DONE: result and flags hold stable while out_valid=1 and out_ready=0.
  - out_ready=1 with no new accept → IDLE, out_valid 0 next cycle.
  - out_ready=1 with a simultaneous accept → the new op is processed. Non-MUL stays in DONE with new data; MUL goes to BUSY with out_valid 0.
- in_ready is 0 throughout BUSY; in_valid is ignored there.
- The outputs result, zero, carry and overflow change only on the accept edge (non-MUL) or on the BUSY→DONE edge.
- Arithmetic:
  - ADD/SUB use a WIDTH+1-bit sum.
  - SUB carry = 1 when a >= b unsigned.
  - overflow = operand signs equal (ADD) or different (SUB), and the result sign differs from a.
  - Shifts by >= WIDTH are impossible by construction, since only SH_W bits are used.
- reset asserted mid-MUL or in DONE: the operation is aborted and the reset values are restored on that edge. No output is produced for the aborted op.

Decomposition:
- alu_pkg: opcode localparams (OP_AND … OP_MUL) and the state encoding.
- One sub-module: alu_mul_iter (start, a, b → busy, done, product; WIDTH-cycle shift-add).
- Combinational single-cycle ops stay inline in alu_mc.

Test Plan:
- Reset, then idle → in_ready=1, out_valid=0, result=0, zero=1; holds for 5 cycles.
- ADD a=0xFFFFFFFF, b=1 with out_ready=1 → next cycle out_valid=1, result=0, zero=1, carry=1, overflow=0.
- ADD a=0x7FFFFFFF, b=1 → overflow=1, carry=0.
- SUB a=3, b=5 → result=0xFFFFFFFE, carry=0.
- SLT a=0x80000000, b=1 → result=1.
- MUL a=0x0001_0003, b=7 → in_ready=0 for 32 cycles; out_valid on cycle 33 after accept; result=0x0007_0015. A second in_valid during BUSY is not accepted.
- Backpressure and back-to-back: issue XOR 0xF0F0^0x0FF0; hold out_ready=0 for 4 cycles → result=0xFF00 stable, in_ready=0. Then raise out_ready with OR 0x1|0x2 waiting → the same cycle accepts it; next result=3 with out_valid continuously 1.
- Reset asserted on the 10th cycle of a MUL → next cycle IDLE, out_valid=0, result=0. A following ADD 2+2 returns 4.
- Opcode 1111 → result=0, zero=1, latency 1.
